// File: rtl/alex_spi_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alex_spi_tx                                                                |
// | Shifts {rx_word, ptt, lpf} to the Alex relay board whenever it changes.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module alex_spi_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FRAME_BITS = 24
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [6:0]  lpf,
  input  logic        ptt,
  input  logic [15:0] rx_word,
  output logic        spi_clk,
  output logic        spi_data,
  output logic        spi_load,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    LOAD     = 3'd3,
    GAP      = 3'd4
  } state_t;

  localparam logic [7:0] c_half_last = 8'(CLK_DIV - 1);
  localparam logic [4:0] c_bit_first = 5'(FRAME_BITS - 1);

  state_t      r_state;
  logic [23:0] r_snap;
  logic [23:0] r_last;
  logic        r_force;
  logic [7:0]  r_half;
  logic [4:0]  r_bit;

  logic [23:0] w_frame;
  logic        w_trigger;
  logic        w_half_done;

  assign w_frame     = {rx_word, ptt, lpf};
  assign w_trigger   = (w_frame != r_last) || r_force;
  assign w_half_done = (r_half == c_half_last);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_snap   <= '0;
      r_last   <= '0;
      r_force  <= 1'b1;
      r_half   <= '0;
      r_bit    <= '0;
      spi_clk  <= 1'b0;
      spi_data <= 1'b0;
      spi_load <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_half <= '0;
          // Bit 23 goes straight to the pin so it is valid on the first busy cycle.
          if (w_trigger) begin
            r_snap   <= w_frame;
            r_force  <= 1'b0;
            r_bit    <= c_bit_first;
            spi_clk  <= 1'b0;
            spi_data <= w_frame[23];
            busy     <= 1'b1;
            r_state  <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (w_half_done) begin
            r_half  <= '0;
            spi_clk <= 1'b1;
            r_state <= SHIFT_HI;
          end else begin
            r_half <= r_half + 8'd1;
          end
        end
        SHIFT_HI: begin
          if (w_half_done) begin
            r_half  <= '0;
            spi_clk <= 1'b0;
            if (r_bit == 5'd0) begin
              spi_data <= 1'b0;
              spi_load <= 1'b1;
              r_state  <= LOAD;
            end else begin
              r_bit    <= r_bit - 5'd1;
              spi_data <= r_snap[r_bit - 5'd1];
              r_state  <= SHIFT_LO;
            end
          end else begin
            r_half <= r_half + 8'd1;
          end
        end
        LOAD: begin
          if (w_half_done) begin
            r_half   <= '0;
            spi_load <= 1'b0;
            r_last   <= r_snap;
            r_state  <= GAP;
          end else begin
            r_half <= r_half + 8'd1;
          end
        end
        GAP: begin
          if (w_half_done) begin
            r_half  <= '0;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_half <= r_half + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
